// File: rtl/adc_stream_pkg.sv
// Shared types for the ADC frame stream: one frame is four samples, emitted as two AXIS beats.
package adc_stream_pkg;

  localparam int DEF_SAMPLE_W = 16;
  localparam int NUM_CH       = 4;

  // ch4 sits in the MSBs so the struct overlays ch_data bit-for-bit
  typedef struct packed {
    logic [DEF_SAMPLE_W-1:0] ch4;
    logic [DEF_SAMPLE_W-1:0] ch3;
    logic [DEF_SAMPLE_W-1:0] ch2;
    logic [DEF_SAMPLE_W-1:0] ch1;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } beat_state_t;

  function automatic logic [2*DEF_SAMPLE_W-1:0] beat_lo(input frame_t f);
    return {f.ch2, f.ch1};
  endfunction

  function automatic logic [2*DEF_SAMPLE_W-1:0] beat_hi(input frame_t f);
    return {f.ch4, f.ch3};
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame FIFO; pointers carry one extra wrap bit so full/empty come from an MSB compare.
module frame_fifo
  import adc_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  frame_t                   din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output frame_t                   head
);

  localparam int AW = $clog2(DEPTH);

  frame_t        r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_ptr_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the packer never exposes a slot before it is written.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign w_ptr_match = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign full        = w_ptr_match && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign empty       = w_ptr_match && (r_wr_ptr[AW] == r_rd_ptr[AW]);
  assign level       = r_wr_ptr - r_rd_ptr;
  assign head        = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/adc_frame_packer.sv
// Buffers 4-channel ADC frames and streams each as two AXIS beats; counts frames lost to backpressure.
// state | meaning
// IDLE  | nothing to send, tvalid low
// BEAT0 | presenting {ch2,ch1} of head frame, tlast low
// BEAT1 | presenting {ch4,ch3} of head frame, tlast high; handshake pops
module adc_frame_packer
  import adc_stream_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int FIFO_DEPTH = 4,
  parameter int OVF_CNT_W  = 16
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_aresetn,
  input  logic                            enable,
  input  logic                            sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]      ch_data,
  input  logic                            clear_status,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [2*SAMPLE_W-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [OVF_CNT_W-1:0]            ovf_count,
  output logic                            ovf_sticky,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  beat_state_t           r_state;
  beat_state_t           w_state_nxt;
  logic [OVF_CNT_W-1:0]  r_ovf_count;
  logic                  r_ovf_sticky;

  frame_t                w_frame_in;
  frame_t                w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [LVL_W-1:0]      w_level;
  logic                  w_strobe;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_more;

  assign w_frame_in = frame_t'(ch_data);
  assign w_strobe   = sample_valid && enable;
  assign w_pop      = (r_state == BEAT1) && m_axis_tready;
  assign w_push     = w_strobe && (!w_full || w_pop);
  assign w_drop     = w_strobe && w_full && !w_pop;
  // A frame arriving during the final pop lands in the next head slot, so it counts as buffered.
  assign w_more     = (w_level > LVL_W'(1)) || w_push;

  frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (m_axis_aclk),
    .rst_n (m_axis_aresetn),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_frame_in),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level),
    .head  (w_head)
  );

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = BEAT0;
      BEAT0:   if (m_axis_tready) w_state_nxt = BEAT1;
      BEAT1:   if (m_axis_tready) w_state_nxt = w_more ? BEAT0 : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode only the state flop and the head slot, which cannot change while stalled.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (r_state)
      BEAT0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = beat_lo(w_head);
      end
      BEAT1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = beat_hi(w_head);
        m_axis_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_ovf_count  <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (clear_status) begin
      r_ovf_count  <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (w_drop) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign ovf_count  = r_ovf_count;
  assign ovf_sticky = r_ovf_sticky;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: beat order, stalls, overflow, reset mid-frame, saturation.
module tb_adc_frame_packer;

  logic        clk;
  logic        aresetn;
  logic        enable;
  logic        sample_valid;
  logic [63:0] ch_data;
  logic        clear_status;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [3:0]  ovf_count;
  logic        ovf_sticky;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  adc_frame_packer #(
    .SAMPLE_W   (16),
    .FIFO_DEPTH (4),
    .OVF_CNT_W  (4)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (aresetn),
    .enable         (enable),
    .sample_valid   (sample_valid),
    .ch_data        (ch_data),
    .clear_status   (clear_status),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .m_axis_tlast   (tlast),
    .ovf_count      (ovf_count),
    .ovf_sticky     (ovf_sticky),
    .fifo_level     (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] frame_of(input int k);
    return {16'(k*256+4), 16'(k*256+3), 16'(k*256+2), 16'(k*256+1)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int k);
    sample_valid = 1'b1;
    ch_data      = frame_of(k);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic push_exp(input int k);
    exp_q.push_back({16'(k*256+2), 16'(k*256+1)});
    exp_q.push_back({16'(k*256+4), 16'(k*256+3)});
  endtask

  // Consumes every queued beat; toggle=1 alternates tready to exercise stalls.
  task automatic drain(input bit toggle, input string tag);
    int idx = 0;
    int n   = exp_q.size();
    int cyc = 0;
    while (idx < n && cyc < 200) begin
      if (tvalid) begin
        check({tag, "_data"}, tdata, exp_q[idx]);
        check({tag, "_last"}, tlast, idx % 2);
      end
      tready = toggle ? ~cyc[0] : 1'b1;
      if (tvalid && tready) idx++;
      cyc++;
      tick();
    end
    check({tag, "_count"}, idx, n);
    tready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    aresetn      = 1'b0;
    enable       = 1'b1;
    sample_valid = 1'b0;
    ch_data      = '0;
    clear_status = 1'b0;
    tready       = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_ovf", ovf_count, 0);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_level", fifo_level, 0);
    aresetn = 1'b1;
    tick();

    // single frame, latency and beat order
    tready       = 1'b1;
    sample_valid = 1'b1;
    ch_data      = 64'h4444_3333_2222_1111;
    tick();
    sample_valid = 1'b0;
    check("t1_idle_tvalid", tvalid, 0);
    check("t1_level", fifo_level, 1);
    tick();
    check("t1_b0_tvalid", tvalid, 1);
    check("t1_b0_data", tdata, 32'h2222_1111);
    check("t1_b0_last", tlast, 0);
    tick();
    check("t1_b1_tvalid", tvalid, 1);
    check("t1_b1_data", tdata, 32'h4444_3333);
    check("t1_b1_last", tlast, 1);
    tick();
    check("t1_end_tvalid", tvalid, 0);
    check("t1_end_level", fifo_level, 0);

    // overflow under backpressure, then ordered drain
    tready = 1'b0;
    for (int k = 10; k < 15; k++) strobe(k);
    check("t2_level", fifo_level, 4);
    check("t2_ovf", ovf_count, 1);
    check("t2_sticky", ovf_sticky, 1);
    for (int k = 10; k < 14; k++) push_exp(k);
    drain(1'b0, "t2");
    check("t2_end_level", fifo_level, 0);
    check("t2_end_tvalid", tvalid, 0);

    // tready toggling every cycle
    strobe(20);
    strobe(21);
    push_exp(20);
    push_exp(21);
    drain(1'b1, "t3");
    check("t3_end_level", fifo_level, 0);

    // full FIFO, push coincident with BEAT1 pop
    for (int k = 30; k < 34; k++) strobe(k);
    check("t4_full_level", fifo_level, 4);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("t4_b1_last", tlast, 1);
    tready       = 1'b1;
    sample_valid = 1'b1;
    ch_data      = frame_of(34);
    tick();
    sample_valid = 1'b0;
    tready       = 1'b0;
    check("t4_level", fifo_level, 4);
    check("t4_ovf", ovf_count, 1);
    check("t4_next_data", tdata, {16'(31*256+2), 16'(31*256+1)});
    for (int k = 31; k < 35; k++) push_exp(k);
    drain(1'b0, "t4");

    // async reset after BEAT0 handshake
    strobe(40);
    tick();
    check("t5_b0_last", tlast, 0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("t5_b1_last", tlast, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", tvalid, 0);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_ovf", ovf_count, 0);
    tick();
    aresetn = 1'b1;
    tick();
    strobe(42);
    push_exp(42);
    drain(1'b0, "t5");

    // counter saturation, clear priority, enable gating
    for (int k = 50; k < 54; k++) strobe(k);
    for (int i = 0; i < 17; i++) strobe(60);
    check("t6_sat", ovf_count, 15);
    check("t6_sat_sticky", ovf_sticky, 1);
    check("t6_sat_level", fifo_level, 4);
    sample_valid = 1'b1;
    clear_status = 1'b1;
    ch_data      = frame_of(61);
    tick();
    sample_valid = 1'b0;
    clear_status = 1'b0;
    check("t6_clr_ovf", ovf_count, 0);
    check("t6_clr_sticky", ovf_sticky, 0);
    strobe(62);
    check("t6_drop_ovf", ovf_count, 1);
    check("t6_drop_sticky", ovf_sticky, 1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("t6_clr2_ovf", ovf_count, 0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) strobe(63);
    check("t6_dis_ovf", ovf_count, 0);
    check("t6_dis_sticky", ovf_sticky, 0);
    check("t6_dis_level", fifo_level, 4);
    for (int k = 50; k < 54; k++) push_exp(k);
    drain(1'b0, "t6");
    strobe(64);
    strobe(64);
    tick();
    check("t6_dis_empty_level", fifo_level, 0);
    check("t6_dis_empty_tvalid", tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
